// File: rtl/glip_uart_credit_scheduler.sv
// glip_uart_credit_scheduler
// Credit controller for the GLIP UART backend. Tracks ingress bytes freed by
// FIFO pops and grants them back to the host in credit messages, and tracks
// the device-to-host credit that the host has granted to the egress path.

module glip_uart_credit_scheduler #(
   parameter int FIFO_DEPTH       = 256,
   parameter int CREDIT_THRESHOLD = 64,
   parameter int FLUSH_CYCLES     = 1024
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_ingress_pop,
   output logic [14:0] o_credit,
   output logic        o_credit_en,
   input  logic        i_credit_ack,
   input  logic [14:0] i_rx_credit,
   input  logic        i_rx_credit_valid,
   input  logic        i_transfer,
   output logic        o_can_send,
   output logic        o_error
);

   localparam int PW = $clog2(FIFO_DEPTH + 1);
   localparam int FW = $clog2(FLUSH_CYCLES + 1);
   localparam logic [PW-1:0] DEPTH_P    = PW'(FIFO_DEPTH);
   localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);
   localparam logic [FW-1:0] FLUSH_MAX  = FW'(FLUSH_CYCLES);

   typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_REQ} state_t;

   state_t        r_state, w_stateNext;
   logic [PW-1:0] r_pending, w_pendingNext;
   logic [FW-1:0] r_flush, w_flushNext;
   logic [14:0]   r_credit, w_creditNext;
   logic          r_creditEn, w_creditEnNext;
   logic [15:0]   r_txCredit, w_txNext;
   logic          r_canSend, r_error;
   logic          w_popOk, w_popErr, w_ackOk, w_ackErr, w_txErr;
   logic          w_thrHit, w_subThr, w_flushHit;
   logic [31:0]   w_pendWide;
   logic [16:0]   w_txSum, w_txDiff;

   // Next pending count: a pop that would free more bytes than the FIFO holds is
   // rejected as an error, and an acked grant is removed from the pool.
   always_comb begin
      w_popErr   = i_ingress_pop && (r_pending == DEPTH_P);
      w_popOk    = i_ingress_pop && !w_popErr;
      w_ackOk    = i_credit_ack && (r_state == ST_REQ);
      w_ackErr   = i_credit_ack && (r_state != ST_REQ);
      w_pendWide = 32'(r_pending) + 32'(w_popOk);
      if (w_ackOk) begin
         w_pendWide = w_pendWide - 32'(r_credit);
      end
      w_pendingNext = w_pendWide[PW-1:0];
   end

   // Grant FSM: decides on the next pending value so a threshold crossing is
   // requested on the very edge of the pop that caused it.
   always_comb begin
      w_stateNext    = r_state;
      w_creditEnNext = r_creditEn;
      w_creditNext   = r_credit;
      w_flushNext    = r_flush;
      w_thrHit       = (w_pendWide >= 32'(CREDIT_THRESHOLD));
      w_subThr       = (w_pendWide != 32'd0) && !w_thrHit;
      w_flushHit     = w_subThr && !i_ingress_pop && (r_flush >= FLUSH_LAST);
      unique case (r_state)
         ST_INIT: begin
            w_stateNext    = ST_IDLE;
            w_creditEnNext = 1'b0;
            w_flushNext    = '0;
         end
         ST_IDLE: begin
            if (w_thrHit || w_flushHit) begin
               w_stateNext    = ST_REQ;
               w_creditEnNext = 1'b1;
               w_creditNext   = (w_pendWide > 32'd32767) ? 15'h7fff : w_pendWide[14:0];
               w_flushNext    = '0;
            end else if (!w_subThr || i_ingress_pop) begin
               w_flushNext = '0;
            end else if (r_flush != FLUSH_MAX) begin
               w_flushNext = r_flush + FW'(1);
            end
         end
         ST_REQ: begin
            w_flushNext = '0;
            if (w_ackOk) begin
               w_stateNext    = ST_IDLE;
               w_creditEnNext = 1'b0;
            end
         end
         default: begin
            w_stateNext    = ST_INIT;
            w_creditEnNext = 1'b0;
         end
      endcase
   end

   // Device-to-host credit: add host credit and consume transfers in one step,
   // saturating on overflow and holding at zero on an unfunded transfer.
   always_comb begin
      w_txSum  = 17'(r_txCredit) + (i_rx_credit_valid ? 17'(i_rx_credit) : 17'd0);
      w_txErr  = 1'b0;
      w_txNext = r_txCredit;
      w_txDiff = w_txSum;
      if (i_transfer && (w_txSum == 17'd0)) begin
         w_txErr  = 1'b1;
         w_txNext = 16'd0;
      end else begin
         w_txDiff = w_txSum - 17'(i_transfer);
         if (w_txDiff[16]) begin
            w_txErr  = 1'b1;
            w_txNext = 16'hffff;
         end else begin
            w_txNext = w_txDiff[15:0];
         end
      end
   end

   // FSM state, registered credit request outputs and the flush timer.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state    <= ST_INIT;
         r_creditEn <= 1'b0;
         r_credit   <= 15'd0;
         r_flush    <= '0;
      end else begin
         r_state    <= w_stateNext;
         r_creditEn <= w_creditEnNext;
         r_credit   <= w_creditNext;
         r_flush    <= w_flushNext;
      end
   end

   // Counters, registered can_send and the sticky error flag.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_pending  <= DEPTH_P;
         r_txCredit <= 16'd0;
         r_canSend  <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         r_pending  <= w_pendingNext;
         r_txCredit <= w_txNext;
         r_canSend  <= (w_txNext != 16'd0);
         r_error    <= r_error | w_popErr | w_ackErr | w_txErr;
      end
   end

   assign o_credit    = r_credit;
   assign o_credit_en = r_creditEn;
   assign o_can_send  = r_canSend;
   assign o_error     = r_error;

endmodule

// File: tb/tb_glip_uart_credit_scheduler.sv
// tb_glip_uart_credit_scheduler
// Directed bench for the credit scheduler with FIFO_DEPTH=256,
// CREDIT_THRESHOLD=64 and FLUSH_CYCLES=100.

module tb_glip_uart_credit_scheduler;

   logic        clk;
   logic        rstN;
   logic        ingressPop;
   logic [14:0] credit;
   logic        creditEn;
   logic        creditAck;
   logic [14:0] rxCredit;
   logic        rxCreditValid;
   logic        transfer;
   logic        canSend;
   logic        error;

   int testsRun;
   int testsFailed;

   glip_uart_credit_scheduler #(
      .FIFO_DEPTH      (256),
      .CREDIT_THRESHOLD(64),
      .FLUSH_CYCLES    (100)
   ) dut (
      .i_clk            (clk),
      .i_rst_n          (rstN),
      .i_ingress_pop    (ingressPop),
      .o_credit         (credit),
      .o_credit_en      (creditEn),
      .i_credit_ack     (creditAck),
      .i_rx_credit      (rxCredit),
      .i_rx_credit_valid(rxCreditValid),
      .i_transfer       (transfer),
      .o_can_send       (canSend),
      .o_error          (error)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one observed value against its expected value and count it.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Drive one cycle of inputs, step past the rising edge, then return to idle.
   task automatic applyStimulus(input logic pop, input logic ack, input logic rxValid,
                                input logic [14:0] rxVal, input logic xfer);
      ingressPop    = pop;
      creditAck     = ack;
      rxCreditValid = rxValid;
      rxCredit      = rxVal;
      transfer      = xfer;
      @(posedge clk);
      #1;
      ingressPop    = 1'b0;
      creditAck     = 1'b0;
      rxCreditValid = 1'b0;
      rxCredit      = 15'd0;
      transfer      = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 15'd0, 1'b0);
   endtask

   // Hold reset for two edges and release it just after the second one.
   task automatic applyReset();
      rstN = 1'b0;
      idleCycles(2);
      rstN = 1'b1;
   endtask

   // Reset, then step to the initial full-depth grant.
   task automatic resetToGrant(input string tag);
      applyReset();
      idleCycles(2);
      checkOutput({tag, "_grantEn"}, 32'(creditEn), 32'd1);
   endtask

   // Run n quiet cycles and count how many of them show a request.
   task automatic countRequests(input int n, output int seen);
      seen = 0;
      for (int i = 0; i < n; i++) begin
         idleCycles(1);
         if (creditEn) seen++;
      end
   endtask

   int seen;

   // Directed scenario sequence.
   initial begin
      testsRun      = 0;
      testsFailed   = 0;
      rstN          = 1'b0;
      ingressPop    = 1'b0;
      creditAck     = 1'b0;
      rxCredit      = 15'd0;
      rxCreditValid = 1'b0;
      transfer      = 1'b0;

      // Reset values.
      applyReset();
      checkOutput("rstCreditEn", 32'(creditEn), 32'd0);
      checkOutput("rstCredit",   32'(credit),   32'd0);
      checkOutput("rstCanSend",  32'(canSend),  32'd0);
      checkOutput("rstError",    32'(error),    32'd0);

      // Initial grant on the second edge after release, acked five cycles later.
      idleCycles(1);
      checkOutput("initEdge1En", 32'(creditEn), 32'd0);
      idleCycles(1);
      checkOutput("initEdge2En", 32'(creditEn), 32'd1);
      checkOutput("initCredit",  32'(credit),   32'd256);
      idleCycles(3);
      checkOutput("initHoldEn",  32'(creditEn), 32'd1);
      applyStimulus(1'b0, 1'b1, 1'b0, 15'd0, 1'b0);
      checkOutput("initAckEn",   32'(creditEn), 32'd0);
      countRequests(150, seen);
      checkOutput("initNoReq",   32'(seen), 32'd0);

      // Threshold grant with pops continuing during the request.
      for (int i = 0; i < 63; i++) applyStimulus(1'b1, 1'b0, 1'b0, 15'd0, 1'b0);
      checkOutput("thr63En", 32'(creditEn), 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 15'd0, 1'b0);
      checkOutput("thr64En",     32'(creditEn), 32'd1);
      checkOutput("thr64Credit", 32'(credit),   32'd64);
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b0, 15'd0, 1'b0);
      checkOutput("thrReqCredit", 32'(credit), 32'd64);
      applyStimulus(1'b0, 1'b1, 1'b0, 15'd0, 1'b0);
      checkOutput("thrAckEn", 32'(creditEn), 32'd0);
      checkOutput("thrError", 32'(error),    32'd0);
      countRequests(99, seen);
      checkOutput("thrNoEarlyReq", 32'(seen), 32'd0);
      idleCycles(1);
      checkOutput("thrFlushEn",     32'(creditEn), 32'd1);
      checkOutput("thrFlushCredit", 32'(credit),   32'd10);
      applyStimulus(1'b0, 1'b1, 1'b0, 15'd0, 1'b0);

      // Flush of a small credit exactly 100 cycles after the last pop.
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 15'd0, 1'b0);
      countRequests(99, seen);
      checkOutput("flushNoEarlyReq", 32'(seen), 32'd0);
      idleCycles(1);
      checkOutput("flushEn",     32'(creditEn), 32'd1);
      checkOutput("flushCredit", 32'(credit),   32'd5);
      applyStimulus(1'b0, 1'b1, 1'b0, 15'd0, 1'b0);
      checkOutput("flushAckEn", 32'(creditEn), 32'd0);
      countRequests(120, seen);
      checkOutput("flushNoReq", 32'(seen), 32'd0);

      // Device-to-host credit tracking.
      applyStimulus(1'b0, 1'b0, 1'b1, 15'd3, 1'b0);
      checkOutput("txRx3CanSend", 32'(canSend), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 15'd0, 1'b1);
      checkOutput("txXfer1CanSend", 32'(canSend), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 15'd0, 1'b1);
      checkOutput("txXfer2CanSend", 32'(canSend), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 15'd0, 1'b1);
      checkOutput("txXfer3CanSend", 32'(canSend), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b1, 15'd1, 1'b0);
      checkOutput("txRx1CanSend", 32'(canSend), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b1, 15'd1, 1'b1);
      checkOutput("txSameCycleCanSend", 32'(canSend), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 15'd0, 1'b1);
      checkOutput("txDrainCanSend", 32'(canSend), 32'd0);
      checkOutput("txError", 32'(error), 32'd0);

      // Error: transfer with no device-to-host credit.
      applyReset();
      applyStimulus(1'b0, 1'b0, 1'b0, 15'd0, 1'b1);
      checkOutput("errXferError",   32'(error),   32'd1);
      checkOutput("errXferCanSend", 32'(canSend), 32'd0);
      idleCycles(3);
      checkOutput("errXferSticky", 32'(error), 32'd1);

      // Error: pop while the whole FIFO depth is already pending a grant.
      resetToGrant("errPop");
      checkOutput("errPopBefore", 32'(error), 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 15'd0, 1'b0);
      checkOutput("errPopError", 32'(error), 32'd1);
      idleCycles(3);
      checkOutput("errPopSticky", 32'(error), 32'd1);

      // Error: acknowledge while idle.
      resetToGrant("errAck");
      applyStimulus(1'b0, 1'b1, 1'b0, 15'd0, 1'b0);
      checkOutput("errAckLegit", 32'(error), 32'd0);
      idleCycles(2);
      applyStimulus(1'b0, 1'b1, 1'b0, 15'd0, 1'b0);
      checkOutput("errAckError", 32'(error),    32'd1);
      checkOutput("errAckEn",    32'(creditEn), 32'd0);
      idleCycles(3);
      checkOutput("errAckSticky", 32'(error), 32'd1);

      // Error: device-to-host credit overflow; the grant stays outstanding.
      resetToGrant("errOvf");
      applyStimulus(1'b0, 1'b0, 1'b1, 15'd32767, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 15'd32767, 1'b0);
      checkOutput("errOvfBefore", 32'(error), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b1, 15'd32767, 1'b0);
      checkOutput("errOvfError",   32'(error),   32'd1);
      checkOutput("errOvfCanSend", 32'(canSend), 32'd1);
      idleCycles(3);
      checkOutput("errOvfSticky", 32'(error),    32'd1);
      checkOutput("midReqEnBefore", 32'(creditEn), 32'd1);

      // Reset while a request is outstanding, then a fresh full-depth grant.
      rstN = 1'b0;
      idleCycles(1);
      checkOutput("midRstEn",      32'(creditEn), 32'd0);
      checkOutput("midRstError",   32'(error),    32'd0);
      checkOutput("midRstCanSend", 32'(canSend),  32'd0);
      rstN = 1'b1;
      idleCycles(1);
      checkOutput("midRelEdge1En", 32'(creditEn), 32'd0);
      idleCycles(1);
      checkOutput("midRelEdge2En", 32'(creditEn), 32'd1);
      checkOutput("midRelCredit",  32'(credit),   32'd256);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/glip_uart_credit_scheduler.md
# glip_uart_credit_scheduler

Credit controller for the GLIP UART backend, sitting between the ingress FIFO, the ingress control-word decoder and the egress multiplexer. It decides when and how much host-to-device credit to grant, and drives the egress credit request handshake (`credit`/`credit_en`/`credit_ack`). It also tracks device-to-host credit granted by the host and produces `can_send` for the egress path.

## Interface

- `FIFO_DEPTH`, 256: ingress FIFO depth in bytes; range 1..32767.
- `CREDIT_THRESHOLD`, 64: minimum freed bytes before a normal credit grant; range 1..`FIFO_DEPTH`.
- `FLUSH_CYCLES`, 1024: idle cycles after which a sub-threshold non-zero credit is flushed; range ≥1.
- `clk`  in  1  single clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `ingress_pop`  in  1  one byte consumed from the ingress FIFO this cycle.
- `credit`  out  15  credit value to transmit; stable while `credit_en`=1.
- `credit_en`  out  1  credit message request to egress.
- `credit_ack`  in  1  egress finished sending the credit message (single-cycle pulse).
- `rx_credit`  in  15  credit value decoded from the host.
- `rx_credit_valid`  in  1  `rx_credit` valid this cycle.
- `transfer`  in  1  one user byte accepted by egress.
- `can_send`  out  1  device-to-host credit available.
- `error`  out  1  sticky protocol error.

## Operation

- **pending** counter, width clog2(`FIFO_DEPTH`+1): bytes freed but not yet granted.
  - Loaded with `FIFO_DEPTH` on reset.
  - +1 per `ingress_pop`.
  - On `credit_ack`: pending ← pending − latched `credit` + `ingress_pop`.
  - A pop when pending + outstanding grant = `FIFO_DEPTH` sets `error` and leaves pending unchanged.
- **FSM states**
  - **INIT**: entered on reset; lasts one cycle, then goes to IDLE.
  - **IDLE**:
    - If pending ≥ `CREDIT_THRESHOLD`, or (pending > 0 and flush counter = `FLUSH_CYCLES`): latch `credit` = min(pending, 32767), assert `credit_en`, go to REQ.
    - The initial full-depth grant takes this path on the first IDLE cycle.
  - **REQ**:
    - Hold `credit_en`=1 and `credit` unchanged.
    - Pops continue to accumulate into pending.
    - On `credit_ack`: subtract the latched value, clear `credit_en`, go to IDLE.
- **Flush counter**
  - Counts cycles in IDLE while 0 < pending < `CREDIT_THRESHOLD`.
  - Cleared on entry to REQ and whenever pending = 0.
  - Saturates at `FLUSH_CYCLES`.
- **tx_credit** counter, 16 bits: device-to-host credit.
  - Next value = tx_credit + (`rx_credit_valid` ? `rx_credit` : 0) − `transfer`.
  - Simultaneous add and decrement are applied in the same cycle.
  - On overflow beyond 65535: saturate at 65535 and set `error`.
  - `transfer` while tx_credit = 0 and no same-cycle credit: counter stays 0, set `error`.
  - `can_send` = (tx_credit != 0), registered.
- **Error handling**
  - `credit_ack` outside REQ sets `error` and is otherwise ignored.
  - `error` stays set until reset.

## Timing

- **Reset values**: `credit_en`=0, `credit`=0, `can_send`=0, `error`=0, tx_credit=0, pending=`FIFO_DEPTH`, flush counter=0, state INIT.
- **First grant**: `credit_en` rises on the second rising edge after `rst_n` goes high (INIT, then IDLE decision), with `credit` = min(`FIFO_DEPTH`, 32767).
- **Outputs**: all outputs are registered; no input reaches an output combinationally.
- **credit_en release**: `credit_en` falls on the edge following the `credit_ack` cycle.
- **Minimum gap**: `credit_en` stays low for at least one full cycle between requests, so egress in its idle state never sees a stale request.
- **Request latency**: a threshold crossing caused by a pop in cycle N asserts `credit_en` in cycle N+1 when the FSM is in IDLE.
- **can_send latency**: updated one cycle after the `rx_credit_valid`/`transfer` event that changes it.
- **Reset mid-request**: `rst_n` low in REQ clears `credit_en` at the next edge and discards the latched grant. The full-depth grant is reissued after reset.

## Test plan

All scenarios use `FIFO_DEPTH`=256, `CREDIT_THRESHOLD`=64, `FLUSH_CYCLES`=100.

- **Initial grant**: release `rst_n`, then ack after 5 cycles -> `credit_en`=1 on the 2nd edge with `credit`=256; `credit_en`=0 on the cycle after ack; pending=0; no further request.
- **Threshold grant with pops in flight**: 64 pops -> `credit_en` with `credit`=64; 10 more pops while in REQ, then ack -> pending=10; no request until the flush timeout.
- **Flush**: 5 pops then quiet -> `credit_en` with `credit`=5 exactly 100 IDLE cycles after the last pop; ack -> pending=0.
- **tx_credit tracking**:
  - `rx_credit_valid` with `rx_credit`=3 -> `can_send`=1 next cycle.
  - 3 transfers -> `can_send`=0 the cycle after the third.
  - Same-cycle `rx_credit`=1 and `transfer` at count 1 -> count stays 1, `can_send` stays 1.
- **Error cases**: each of the following sets `error`, which stays 1 until reset:
  - `transfer` at tx_credit=0.
  - A pop after the full 256-byte grant with no further credit.
  - `credit_ack` in IDLE.
  - `rx_credit`=32767 applied three times (saturates at 65535).
- **Reset mid-request**: pull `rst_n` low while `credit_en`=1 -> `credit_en`=0 next edge, `error`=0; after release, a new request with `credit`=256.
